// File: rtl/axi_read_arbiter.sv
// AR-channel read arbiter for three masters: registered one-hot grant held from AR issue to RLAST.
// Define AXI_RD_ARB_RR_EN for round-robin; otherwise fixed priority m0 > m1 > m2.
`ifndef LEN_BITS
`define LEN_BITS 8
`endif

module axi_read_arbiter #(
    parameter int unsigned LEN_BITS = `LEN_BITS
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                m0_ARVALID,
    input  logic                m1_ARVALID,
    input  logic                m2_ARVALID,
    input  logic                arvalid,
    input  logic                arready,
    input  logic [LEN_BITS-1:0] arlen,
    input  logic                rvalid,
    input  logic                rready,
    input  logic                rlast,
    output logic                m0_rgrnt,
    output logic                m1_rgrnt,
    output logic                m2_rgrnt,
    output logic                rd_busy,
    output logic                rd_len_err
);

    localparam int unsigned NUM_M = 3;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e               state_q, state_d;
    logic [NUM_M-1:0]     grant_q, grant_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [LEN_BITS:0]    beat_cnt_q, beat_cnt_d;
    logic                 ovr_q, ovr_d;
    logic                 err_q, err_d;
    logic [NUM_M-1:0]     req;
    logic [1:0]           win_idx;
    logic                 win_vld;
    logic [LEN_BITS:0]    len_ext;

`ifdef AXI_RD_ARB_RR_EN
    logic [1:0]           idx_q, idx_d;
    logic [1:0]           ptr_q, ptr_d;
`endif

    assign req     = {m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign len_ext = {1'b0, len_q};

    // Winner search: start at the pointer, wrap m0 -> m1 -> m2
    always_comb begin
        win_vld = |req;
`ifdef AXI_RD_ARB_RR_EN
        case (ptr_q)
            2'd1:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
`else
        win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
            idx_q      <= 2'd0;
            ptr_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
`ifdef AXI_RD_ARB_RR_EN
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        ovr_d      = ovr_q;
        err_d      = 1'b0;
`ifdef AXI_RD_ARB_RR_EN
        idx_d      = idx_q;
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d = StAddr;
                    grant_d = 3'b001 << win_idx;
`ifdef AXI_RD_ARB_RR_EN
                    idx_d   = win_idx;
`endif
                end
            end
            StAddr: begin
                if (arvalid && arready) begin
                    state_d    = StData;
                    len_d      = arlen;
                    beat_cnt_d = '0;
                    ovr_d      = 1'b0;
                end
            end
            StData: begin
                if (rvalid && rready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (rlast) begin
                        state_d = StIdle;
                        grant_d = '0;
                        err_d   = (beat_cnt_q != len_ext);
`ifdef AXI_RD_ARB_RR_EN
                        ptr_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
`endif
                    end else if ((beat_cnt_q == len_ext) && !ovr_q) begin
                        // Expected last beat arrived without RLAST; flag once per burst
                        err_d = 1'b1;
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        m0_rgrnt   = grant_q[0];
        m1_rgrnt   = grant_q[1];
        m2_rgrnt   = grant_q[2];
        rd_busy    = (state_q != StIdle);
        rd_len_err = err_q;
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: vector table plus hand-written reset/rotation sequences,
// all expectations routed through a scoreboard queue.
`ifndef LEN_BITS
`define LEN_BITS 8
`endif

module tb_axi_read_arbiter;

    localparam int LB = `LEN_BITS;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          m0_ARVALID, m1_ARVALID, m2_ARVALID;
    logic          arvalid, arready;
    logic [LB-1:0] arlen;
    logic          rvalid, rready, rlast;
    logic          m0_rgrnt, m1_rgrnt, m2_rgrnt;
    logic          rd_busy, rd_len_err;

    axi_read_arbiter dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m0_ARVALID (m0_ARVALID),
        .m1_ARVALID (m1_ARVALID),
        .m2_ARVALID (m2_ARVALID),
        .arvalid    (arvalid),
        .arready    (arready),
        .arlen      (arlen),
        .rvalid     (rvalid),
        .rready     (rready),
        .rlast      (rlast),
        .m0_rgrnt   (m0_rgrnt),
        .m1_rgrnt   (m1_rgrnt),
        .m2_rgrnt   (m2_rgrnt),
        .rd_busy    (rd_busy),
        .rd_len_err (rd_len_err)
    );

    always #5 ACLK = ~ACLK;

    // exp layout: {m2_rgrnt, m1_rgrnt, m0_rgrnt, rd_busy, rd_len_err}
    typedef struct {
        logic [2:0]    arv;
        logic          av;
        logic          ar;
        logic [LB-1:0] len;
        logic          rv;
        logic          rr;
        logic          rl;
        logic [4:0]    exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [2:0] rr_exp [4];

    function automatic vec_t mk(logic [2:0] arv, logic av, logic ar, int len,
                                logic rv, logic rr, logic rl, logic [4:0] e);
        vec_t v;
        v.arv = arv; v.av = av; v.ar = ar; v.len = LB'(len);
        v.rv = rv; v.rr = rr; v.rl = rl; v.exp = e;
        return v;
    endfunction

    task automatic apply(vec_t v);
        {m2_ARVALID, m1_ARVALID, m0_ARVALID} = v.arv;
        arvalid = v.av;
        arready = v.ar;
        arlen   = v.len;
        rvalid  = v.rv;
        rready  = v.rr;
        rlast   = v.rl;
    endtask

    task automatic expect_out(string name, logic [4:0] e);
        sb_t s;
        s.name = name;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check_out();
        sb_t        s;
        logic [4:0] act;
        act = {m2_rgrnt, m1_rgrnt, m0_rgrnt, rd_busy, rd_len_err};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %b with no expected entry", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b required %b (g2 g1 g0 busy err)", s.name, act, s.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
`ifdef AXI_RD_ARB_RR_EN
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        // m1 single burst, arlen=3, one stalled beat, rlast on 4th beat
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 0, 0, 5'b010_1_0));
        vecs.push_back(mk(3'b010, 1, 1, 3, 0, 0, 0, 5'b010_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b010_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 5'b010_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b010_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b010_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 1, 5'b000_0_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 5'b000_0_0));
        // Length error: arlen=2, rlast on beat 2
        vecs.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b001, 1, 1, 2, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 1, 5'b000_0_1));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 5'b000_0_0));
        // Overrun: arlen=0, missing rlast on beat 1, rlast late on beat 3
        vecs.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b001, 1, 1, 0, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b001_1_1));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 1, 5'b000_0_1));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 5'b000_0_0));
        // Slow slave: m0 holds grant while m2 requests and arready is low 5 cycles
        vecs.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0, 5'b001_1_0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(3'b100, 1, 0, 0, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b100, 0, 1, 0, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b100, 1, 1, 0, 0, 0, 0, 5'b001_1_0));
        vecs.push_back(mk(3'b100, 0, 0, 0, 1, 1, 1, 5'b000_0_0));
        vecs.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0, 5'b100_1_0));
        vecs.push_back(mk(3'b100, 1, 1, 1, 0, 0, 0, 5'b100_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b100_1_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 1, 5'b000_0_0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 5'b000_0_0));

        // Reset held with all masters requesting
        apply(mk(3'b111, 0, 0, 0, 0, 0, 0, 5'b0));
        ARESETn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_out($sformatf("in_reset_%0d", i), 5'b000_0_0);
            cyc();
            check_out();
        end
        ARESETn = 1'b1;
        expect_out("post_reset_m0", 5'b001_1_0);
        cyc();
        check_out();
        apply(mk(3'b000, 1, 1, 0, 0, 0, 0, 5'b0));
        expect_out("post_reset_ar", 5'b001_1_0);
        cyc();
        check_out();
        apply(mk(3'b000, 0, 0, 0, 1, 1, 1, 5'b0));
        expect_out("post_reset_release", 5'b000_0_0);
        cyc();
        check_out();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            expect_out($sformatf("vec%0d", i), vecs[i].exp);
            cyc();
            check_out();
        end

        // All masters requesting, 1-beat bursts: rotation order and idle gap
        for (int k = 0; k < 4; k++) begin
            apply(mk(3'b111, 0, 0, 0, 0, 0, 0, 5'b0));
            expect_out($sformatf("rr_grant_%0d", k), {rr_exp[k], 2'b10});
            cyc();
            check_out();
            apply(mk(3'b111, 1, 1, 0, 0, 0, 0, 5'b0));
            expect_out($sformatf("rr_addr_%0d", k), {rr_exp[k], 2'b10});
            cyc();
            check_out();
            apply(mk(3'b111, 0, 0, 0, 1, 1, 1, 5'b0));
            expect_out($sformatf("rr_idle_%0d", k), 5'b000_0_0);
            cyc();
            check_out();
        end

        // Asynchronous reset in the middle of an m1 data phase
        apply(mk(3'b010, 0, 0, 0, 0, 0, 0, 5'b0));
        expect_out("mid_grant_m1", 5'b010_1_0);
        cyc();
        check_out();
        apply(mk(3'b010, 1, 1, 3, 0, 0, 0, 5'b0));
        expect_out("mid_addr", 5'b010_1_0);
        cyc();
        check_out();
        apply(mk(3'b000, 0, 0, 0, 1, 1, 0, 5'b0));
        expect_out("mid_beat", 5'b010_1_0);
        cyc();
        check_out();
        apply(mk(3'b111, 0, 0, 0, 1, 1, 0, 5'b0));
        #2;
        ARESETn = 1'b0;
        #1;
        expect_out("async_clear", 5'b000_0_0);
        check_out();
        expect_out("async_held", 5'b000_0_0);
        cyc();
        check_out();
        ARESETn = 1'b1;
        apply(mk(3'b111, 0, 0, 0, 0, 0, 0, 5'b0));
        expect_out("restart_m0", 5'b001_1_0);
        cyc();
        check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
